shift_add_mul_ctrl: RTL and testbench
=====================================

// Module: shift_add_mul_ctrl
// PURPOSE
//   Multi-cycle unsigned multiply(-accumulate) sequencer for the execute stage (UMULL/UMLAL class ops).
//   Drives one shared 2*WIDTH-bit add per cycle: shifted multiplicand onto a running product, radix-2, LSB first.
//   Start/ready input handshake and valid/ready result handshake; pipeline flush aborts the operation.
// PARAMETERS
//   WIDTH       32  operand width; product/accumulator width is 2*WIDTH
//   EARLY_EXIT  1   1: stop once remaining multiplier bits are all zero; 0: always WIDTH iterations
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous reset, active-high
//   flush      in   1        abort current op (sync, no result)
//   start      in   1        request; accepted when start && in_ready
//   in_ready   out  1        high only in IDLE
//   op_a       in   WIDTH    multiplicand
//   op_b       in   WIDTH    multiplier
//   acc_en     in   1        1: initial product = acc_in; 0: initial product = 0
//   acc_in     in   2*WIDTH  accumulate addend
//   out_valid  out  1        result valid (DONE state)
//   out_ready  in   1        consumer takes result when out_valid && out_ready
//   result     out  2*WIDTH  product register
//   busy       out  1        high in ITER or DONE
// BEHAVIOUR
//   States: IDLE, ITER, DONE. Registers: mcand (2*WIDTH), mplier (WIDTH), prod (2*WIDTH), iter (clog2(WIDTH)).
//   Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal regs 0.
//   IDLE: on start (and !flush) at edge: mcand={0,op_a}, mplier=op_b, prod=acc_en?acc_in:0, iter=0 -> ITER.
//     start inputs are sampled only at the accepting edge; later changes are ignored.
//   ITER, each cycle: if mplier[0] prod <= prod + mcand (mod 2^(2*WIDTH), carry-out dropped);
//     mcand <= mcand<<1; mplier <= mplier>>1; iter <= iter+1.
//     -> DONE if iter==WIDTH-1, or EARLY_EXIT && (mplier>>1)==0; else stay.
//     ITER cycles N = WIDTH (EARLY_EXIT=0); N = max(1, msb_index(op_b)+1) (EARLY_EXIT=1).
//   DONE: out_valid=1, result=prod, held stable until out_ready; on out_valid&&out_ready -> IDLE
//     (in_ready high next cycle; no same-cycle re-accept).
//   Latency: accept at edge E; out_valid high from edge E+N+1 onward.
//   result is a register; it keeps the last product after handoff until the next DONE or rst.
//   flush: any state -> IDLE at next edge; out_valid=0; result unchanged; flush beats start and out_ready.
//   rst beats flush; rst mid-ITER/DONE discards op, clears result.
//   start while busy: ignored (in_ready=0), never queued.
// TESTING
//   EARLY_EXIT=0, a=b=0xFFFFFFFF, acc_en=0 -> result 0xFFFFFFFE_00000001, out_valid at E+33.
//   a=3, b=5, acc_en=1, acc_in=0xFFFFFFFF_FFFFFFFF -> result 0x00000000_0000000E (wrap), N=3 (EARLY_EXIT=1).
//   EARLY_EXIT=1, b=0, acc_en=1, acc_in=0x1234 -> result 0x1234, out_valid at E+2.
//   out_ready low 5 cycles in DONE, start pulsed -> result/out_valid stable, in_ready=0, start ignored.
//   flush at iter=10 (b=0xFFFFFFFF) -> IDLE next edge, no out_valid, result keeps prior value; next start accepted.
//   rst asserted in DONE with out_ready low -> out_valid=0, result=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/shift_add_mul_ctrl_if.sv
// ----------------------------------------------------------------------------
// shift_add_mul_ctrl_if
//   Request/result bundle for the shift-add multiply(-accumulate) sequencer.
//   master : issuing side (execute stage / bench)
//   slave  : sequencer
// Signals
//   flush     m->s  abort current op, no result
//   start     m->s  request, taken when start && in_ready
//   in_ready  s->m  sequencer idle
//   op_a      m->s  multiplicand (WIDTH)
//   op_b      m->s  multiplier (WIDTH)
//   acc_en    m->s  seed product with acc_in instead of zero
//   acc_in    m->s  accumulate addend (2*WIDTH)
//   out_valid s->m  result valid
//   out_ready m->s  result consumed when out_valid && out_ready
//   result    s->m  product register (2*WIDTH)
//   busy      s->m  operation in flight or awaiting handoff
// ----------------------------------------------------------------------------
interface shift_add_mul_ctrl_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic                 flush;
    logic                 start;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 acc_en;
    logic [2*WIDTH-1:0]   acc_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;

    modport master (
        output flush, start, op_a, op_b, acc_en, acc_in, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, start, op_a, op_b, acc_en, acc_in, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// ----------------------------------------------------------------------------
// shift_add_mul_ctrl
//   Multi-cycle unsigned multiply(-accumulate) sequencer. Radix-2, LSB first:
//   each ITER cycle conditionally adds the shifted multiplicand onto a
//   running 2*WIDTH-bit product through one shared adder.
// Ports
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of shift_add_mul_ctrl_if (handshakes, operands, result)
// Parameters
//   WIDTH      operand width, product is 2*WIDTH
//   EARLY_EXIT 1: finish once the remaining multiplier bits are zero
// ----------------------------------------------------------------------------
module shift_add_mul_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_add_mul_ctrl_if.slave  bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LastIter = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_prod;
    logic [IW-1:0]     r_iter;
    logic [PW-1:0]     r_result;

    logic              w_accept;
    logic [PW-1:0]     w_prod_sum;
    logic [WIDTH-1:0]  w_mplier_shr;
    logic              w_last;

    // Flush suppresses acceptance so an op can never start on a flush edge.
    assign w_accept     = bus.start && (r_state == StIdle) && !bus.flush;
    // Carry-out beyond 2*WIDTH is intentionally dropped (modular accumulate).
    assign w_prod_sum   = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mplier_shr = r_mplier >> 1;
    assign w_last       = (r_iter == LastIter) || (EARLY_EXIT && (w_mplier_shr == '0));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle: if (w_accept) w_state_next = StIter;
                StIter: if (w_last) w_state_next = StDone;
                StDone: if (bus.out_ready) w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.in_ready  = (r_state == StIdle);
        bus.out_valid = (r_state == StDone);
        bus.busy      = (r_state == StIter) || (r_state == StDone);
        bus.result    = r_result;
    end

    // ---------------- datapath ----------------
    // r_result is separate from r_prod so the last product survives a new
    // accept (which reseeds r_prod) and any flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_iter   <= '0;
            r_result <= '0;
        end else if (!bus.flush) begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{1'b0}}, bus.op_a};
                        r_mplier <= bus.op_b;
                        r_prod   <= bus.acc_en ? bus.acc_in : '0;
                        r_iter   <= '0;
                    end
                end
                StIter: begin
                    r_prod   <= w_prod_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_iter   <= r_iter + IW'(1);
                    if (w_last) begin
                        r_result <= w_prod_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_add_mul_ctrl
//   Drives two sequencers (EARLY_EXIT=1 and EARLY_EXIT=0) with identical
//   stimulus and checks results, latency and handshake behaviour against
//   hand-computed values.
// ----------------------------------------------------------------------------
module tb_shift_add_mul_ctrl;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          acc_en;
    logic [2*W-1:0] acc_in;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_add_mul_ctrl_if #(.WIDTH(W)) ee_if ();
    shift_add_mul_ctrl_if #(.WIDTH(W)) fu_if ();

    assign ee_if.flush     = flush;
    assign ee_if.start     = start;
    assign ee_if.op_a      = op_a;
    assign ee_if.op_b      = op_b;
    assign ee_if.acc_en    = acc_en;
    assign ee_if.acc_in    = acc_in;
    assign ee_if.out_ready = out_ready;
    assign fu_if.flush     = flush;
    assign fu_if.start     = start;
    assign fu_if.op_a      = op_a;
    assign fu_if.op_b      = op_b;
    assign fu_if.acc_en    = acc_en;
    assign fu_if.acc_in    = acc_in;
    assign fu_if.out_ready = out_ready;

    shift_add_mul_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk (clk),
        .rst (rst),
        .bus (ee_if)
    );

    shift_add_mul_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_fu (
        .clk (clk),
        .rst (rst),
        .bus (fu_if)
    );

    // Accepting edge is E. After edge E+k the bench sees out_valid; an
    // out_valid first seen after E+N is the one a consumer samples at E+N+1.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic en, input logic [2*W-1:0] acc,
                          input logic [2*W-1:0] exp_res, input int exp_n_ee);
        int k;
        int n_ee;
        int n_fu;
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        acc_en = en;
        acc_in = acc;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        acc_in = {$urandom, $urandom};
        acc_en = ~en;
        k = 0; n_ee = 0; n_fu = 0;
        while (!fu_if.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (ee_if.out_valid && n_ee == 0) n_ee = k;
            if (fu_if.out_valid && n_fu == 0) n_fu = k;
        end
        n_checks++;
        if (n_ee !== exp_n_ee) begin
            n_fail++;
            $display("FAIL %s latency_ee: got %0d want %0d", name, n_ee, exp_n_ee);
        end
        n_checks++;
        if (n_fu !== W) begin
            n_fail++;
            $display("FAIL %s latency_full: got %0d want %0d", name, n_fu, W);
        end
        n_checks++;
        if (ee_if.result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result_ee: got %h want %h", name, ee_if.result, exp_res);
        end
        n_checks++;
        if (fu_if.result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result_full: got %h want %h", name, fu_if.result, exp_res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if ({ee_if.in_ready, ee_if.out_valid, fu_if.in_ready, fu_if.out_valid} !== 4'b1010) begin
            n_fail++;
            $display("FAIL %s handoff: got rdy/vld ee=%b%b fu=%b%b want 10 10", name,
                     ee_if.in_ready, ee_if.out_valid, fu_if.in_ready, fu_if.out_valid);
        end
        n_checks++;
        if (ee_if.result !== exp_res || fu_if.result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result_after_handoff: got %h/%h want %h", name,
                     ee_if.result, fu_if.result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
        acc_en = 1'b0; acc_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ee_if.in_ready, ee_if.out_valid, ee_if.busy} !== 3'b100 ||
            {fu_if.in_ready, fu_if.out_valid, fu_if.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got ee=%b%b%b fu=%b%b%b want 100", ee_if.in_ready,
                     ee_if.out_valid, ee_if.busy, fu_if.in_ready, fu_if.out_valid, fu_if.busy);
        end
        n_checks++;
        if (ee_if.result !== '0 || fu_if.result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h/%h want 0", ee_if.result, fu_if.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_products();
        run_op("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0,
               64'hFFFF_FFFE_0000_0001, 32);
        run_op("acc_wrap", 32'd3, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_0000_000E, 3);
        run_op("b_zero", 32'hDEAD_BEEF, 32'h0, 1'b1, 64'h1234, 64'h1234, 1);
        run_op("shifted", 32'h0001_0000, 32'h0000_0100, 1'b0, 64'h0, 64'h0100_0000, 9);
    endtask

    task automatic test_hold();
        int k;
        start = 1'b1; op_a = 32'd7; op_b = 32'd6; acc_en = 1'b0; acc_in = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!ee_if.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k !== 3) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d want 3", k);
        end
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; op_a = 32'd100 + i; op_b = 32'd1;
            @(posedge clk);
            #1;
            n_checks++;
            if (ee_if.out_valid !== 1'b1 || ee_if.in_ready !== 1'b0 ||
                ee_if.result !== 64'd42) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h want 1 0 2a", i,
                         ee_if.out_valid, ee_if.in_ready, ee_if.result);
            end
        end
        start = 1'b0;
        k = 0;
        while (!fu_if.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (fu_if.out_valid !== 1'b1 || fu_if.result !== 64'd42) begin
            n_fail++;
            $display("FAIL hold_full_result: got vld=%b res=%h want 1 2a", fu_if.out_valid,
                     fu_if.result);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Start pulses during DONE must not have been queued.
        n_checks++;
        if (ee_if.busy !== 1'b0 || fu_if.busy !== 1'b0 || ee_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_not_queued: got busy=%b/%b rdy=%b want 0 0 1", ee_if.busy,
                     fu_if.busy, ee_if.in_ready);
        end
    endtask

    task automatic test_flush();
        start = 1'b1; op_a = 32'd5; op_b = 32'hFFFF_FFFF; acc_en = 1'b0; acc_in = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if ({ee_if.in_ready, ee_if.out_valid, ee_if.busy} !== 3'b100 ||
            {fu_if.in_ready, fu_if.out_valid, fu_if.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL flush_state: got ee=%b%b%b fu=%b%b%b want 100", ee_if.in_ready,
                     ee_if.out_valid, ee_if.busy, fu_if.in_ready, fu_if.out_valid, fu_if.busy);
        end
        n_checks++;
        if (ee_if.result !== 64'd42 || fu_if.result !== 64'd42) begin
            n_fail++;
            $display("FAIL flush_result_kept: got %h/%h want 2a", ee_if.result, fu_if.result);
        end
        run_op("after_flush", 32'd2, 32'd3, 1'b0, 64'h0, 64'd6, 2);
    endtask

    task automatic test_rst_in_done();
        int k;
        start = 1'b1; op_a = 32'd9; op_b = 32'd1; acc_en = 1'b0; acc_in = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!fu_if.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (ee_if.result !== 64'd9 || fu_if.result !== 64'd9) begin
            n_fail++;
            $display("FAIL rst_pre_result: got %h/%h want 9", ee_if.result, fu_if.result);
        end
        rst = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        n_checks++;
        if ({ee_if.in_ready, ee_if.out_valid, fu_if.in_ready, fu_if.out_valid} !== 4'b1010) begin
            n_fail++;
            $display("FAIL rst_done_flags: got ee=%b%b fu=%b%b want 10 10", ee_if.in_ready,
                     ee_if.out_valid, fu_if.in_ready, fu_if.out_valid);
        end
        n_checks++;
        if (ee_if.result !== '0 || fu_if.result !== '0) begin
            n_fail++;
            $display("FAIL rst_done_result: got %h/%h want 0", ee_if.result, fu_if.result);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_hold();
        test_flush();
        test_rst_in_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
